// File: rtl/credit_tx_if.sv
// Credit-based transmitter bundle: upstream valid/ready, tx strobe,
// credit return and status.
interface credit_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CREDITS    = 4
);
  localparam int CW = $clog2(CREDITS + 1);

  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  credit_ret;
  logic [CW-1:0]         credit_cnt;
  logic                  err;

  modport master (
    output w_valid, w_data, credit_ret,
    input  w_ready, tx_valid, tx_data,
    input  credit_cnt, err
  );

  modport slave (
    input  w_valid, w_data, credit_ret,
    output w_ready, tx_valid, tx_data,
    output credit_cnt, err
  );
endinterface

// File: rtl/credit_tx.sv
// Credit-gated transmitter with 1-cycle registered tx strobe.
// Optional same-cycle credit bypass via CREDIT_TX_BYPASS_EN.
module credit_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CREDITS    = 4
) (
  input logic        clk,
  input logic        rst,
  credit_tx_if.slave bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW:0] MAXC = (CW+1)'(CREDITS);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  txv_q, txv_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;
  logic                  rdy;
  logic                  send;
  logic [CW:0]           sum;

`ifdef CREDIT_TX_BYPASS_EN
  assign rdy = (cnt_q != '0) | bus.credit_ret;
`else
  assign rdy = (cnt_q != '0);
`endif

  assign send = bus.w_valid & rdy;

  always_comb begin
    err_d = err_q;
    txv_d = send;
    txd_d = send ? bus.w_data : txd_q;
    sum   = {1'b0, cnt_q}
          + {{CW{1'b0}}, bus.credit_ret}
          - {{CW{1'b0}}, send};
    // a return past capacity saturates and latches the error
    if (sum > MAXC) begin
      cnt_d = MAXC[CW-1:0];
      err_d = 1'b1;
    end else begin
      cnt_d = sum[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= MAXC[CW-1:0];
      err_q <= 1'b0;
      txv_q <= 1'b0;
      txd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      txv_q <= txv_d;
      txd_q <= txd_d;
    end
  end

  assign bus.w_ready    = rdy;
  assign bus.tx_valid   = txv_q;
  assign bus.tx_data    = txd_q;
  assign bus.credit_cnt = cnt_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_credit_tx.sv
// Scoreboard bench for credit_tx: stimulus pushes expected beats,
// a negedge monitor pops and checks data and 1-cycle latency.
module tb_credit_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;
  exp_t q[$];

  credit_tx_if #(.DATA_WIDTH(8), .CREDITS(4)) bus();

  credit_tx #(.DATA_WIDTH(8), .CREDITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) @cyc %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [7:0] d);
    exp_t e;
    e.d   = d;
    e.due = cyc + 1;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      chk("tx_missing", 0, 1);
    end
    if (bus.tx_valid) begin
      if (q.size() == 0) begin
        chk("tx_unexpected", 1, 0);
      end else begin
        e = q.pop_front();
        chk("tx_data", int'(bus.tx_data), int'(e.d));
        chk("tx_latency", cyc, e.due);
      end
    end
  end

  initial begin
    logic [7:0] dv [4];
    dv[0] = 8'h11; dv[1] = 8'h22;
    dv[2] = 8'h33; dv[3] = 8'h44;
    bus.w_valid    = 1'b0;
    bus.w_data     = '0;
    bus.credit_ret = 1'b0;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_cnt", int'(bus.credit_cnt), 4);
    chk("rst_txv", int'(bus.tx_valid), 0);
    chk("rst_txd", int'(bus.tx_data), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_rdy", int'(bus.w_ready), 1);

    for (int i = 0; i < 4; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = dv[i];
      chk("drain_rdy", int'(bus.w_ready), 1);
      push(dv[i]);
      step();
      chk("drain_cnt", int'(bus.credit_cnt), 3 - i);
    end
    bus.w_data = 8'h99;
    chk("empty_rdy", int'(bus.w_ready), 0);
    step();
    chk("empty_cnt", int'(bus.credit_cnt), 0);
    bus.w_valid = 1'b0;

    bus.credit_ret = 1'b1;
    step();
    bus.credit_ret = 1'b0;
    chk("refill_cnt", int'(bus.credit_cnt), 1);
    chk("refill_rdy", int'(bus.w_ready), 1);
    bus.w_valid = 1'b1;
    bus.w_data  = 8'h55;
    push(8'h55);
    step();
    bus.w_valid = 1'b0;
    chk("refill_cnt0", int'(bus.credit_cnt), 0);
    step();

    bus.credit_ret = 1'b1;
    step();
    step();
    chk("sim_pre_cnt", int'(bus.credit_cnt), 2);
    bus.w_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.w_data = 8'h60 + 8'(i);
      push(bus.w_data);
      step();
      chk("sim_cnt", int'(bus.credit_cnt), 2);
    end
    bus.credit_ret = 1'b0;
    bus.w_data = 8'h70;
    push(8'h70);
    step();
    bus.w_data = 8'h71;
    push(8'h71);
    step();
    chk("byp_pre_cnt", int'(bus.credit_cnt), 0);

    bus.credit_ret = 1'b1;
    bus.w_data     = 8'hA5;
`ifdef CREDIT_TX_BYPASS_EN
    chk("byp_rdy", int'(bus.w_ready), 1);
    push(8'hA5);
    step();
    bus.credit_ret = 1'b0;
    bus.w_valid    = 1'b0;
    chk("byp_cnt", int'(bus.credit_cnt), 0);
`else
    chk("byp_rdy", int'(bus.w_ready), 0);
    step();
    bus.credit_ret = 1'b0;
    chk("byp_cnt1", int'(bus.credit_cnt), 1);
    chk("byp_rdy1", int'(bus.w_ready), 1);
    push(8'hA5);
    step();
    bus.w_valid = 1'b0;
    chk("byp_cnt0", int'(bus.credit_cnt), 0);
`endif
    step();

    bus.credit_ret = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("ovf_pre_cnt", int'(bus.credit_cnt), 4);
    chk("ovf_pre_err", int'(bus.err), 0);
    step();
    bus.credit_ret = 1'b0;
    chk("ovf_err", int'(bus.err), 1);
    chk("ovf_cnt", int'(bus.credit_cnt), 4);
    step();
    bus.w_valid = 1'b1;
    bus.w_data  = 8'h77;
    push(8'h77);
    step();
    bus.w_valid = 1'b0;
    chk("ovf_sticky", int'(bus.err), 1);
    chk("ovf_cnt3", int'(bus.credit_cnt), 3);
    bus.credit_ret = 1'b1;
    step();
    bus.credit_ret = 1'b0;
    chk("ovf_cnt4", int'(bus.credit_cnt), 4);
    chk("ovf_sticky2", int'(bus.err), 1);

    bus.w_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.w_data = 8'hC0 + 8'(i);
      push(bus.w_data);
      step();
    end
    bus.w_valid = 1'b0;
    step();
    chk("mrst_pre_cnt", int'(bus.credit_cnt), 1);
    bus.w_valid    = 1'b1;
    bus.w_data     = 8'hEE;
    bus.credit_ret = 1'b1;
    rst            = 1'b1;
    step();
    rst            = 1'b0;
    bus.w_valid    = 1'b0;
    bus.credit_ret = 1'b0;
    chk("mrst_txv", int'(bus.tx_valid), 0);
    chk("mrst_txd", int'(bus.tx_data), 0);
    chk("mrst_cnt", int'(bus.credit_cnt), 4);
    chk("mrst_err", int'(bus.err), 0);

    step();
    step();
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/credit_tx.md
CREDIT_TX -- requirements
Module: credit_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the payload width in bits.
REQ-002 SHALL have parameter CREDITS, default 4, meaning the receiver buffer capacity in entries; legal range is 1 or more.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; reset is synchronous and active-high.
REQ-005 SHALL have port w_valid, input, 1, upstream data valid.
REQ-006 SHALL have port w_ready, output, 1, upstream ready; a transfer occurs when w_valid and w_ready are both 1.
REQ-007 SHALL have port w_data, input, DATA_WIDTH, upstream payload.
REQ-008 SHALL have port tx_valid, output, 1, one-cycle strobe toward the receiver buffer; there is no ready.
REQ-009 SHALL have port tx_data, output, DATA_WIDTH, payload qualified by tx_valid.
REQ-010 SHALL have port credit_ret, input, 1, pulse worth one returned credit per cycle, asserted when the receiver pops an entry.
REQ-011 SHALL have port credit_cnt, output, $clog2(CREDITS+1), current available credits.
REQ-012 SHALL have port err, output, 1, sticky credit-overflow flag.

Function
REQ-013 SHALL accept an upstream beat (w_ready=1) only when credit_cnt > 0, except as extended by REQ-027.
REQ-014 SHALL derive w_ready combinationally from state only (credit_cnt, and credit_ret per REQ-027), never from w_valid.
REQ-015 SHALL register accepted data: tx_valid=1 and tx_data=w_data exactly one cycle after the handshake cycle; latency fixed at 1.
REQ-016 SHALL drive tx_valid=0 in any cycle following a non-handshake cycle.
REQ-017 SHALL hold tx_data at its last value when tx_valid=0.
REQ-018 SHALL update credit_cnt_next = credit_cnt - send + credit_ret, where send = w_valid & w_ready.
REQ-019 SHALL, on simultaneous send and credit_ret, leave credit_cnt unchanged.
REQ-020 SHALL never let credit_cnt underflow below 0; REQ-013 guarantees this.
REQ-021 SHALL treat a credit_ret that would make credit_cnt exceed CREDITS as an overflow: credit_cnt saturates at CREDITS and err is set to 1.
REQ-022 SHALL keep err at 1 until reset; after err is set, all other behaviour continues unchanged.
REQ-023 SHALL sustain one beat per cycle while credits remain, i.e. full throughput with credit_cnt >= 1 each cycle.
REQ-024 SHALL work for CREDITS=1, using a counter width of 1 bit, with no special-case loss of throughput beyond credit round-trip.

Reset
REQ-025 SHALL, when rst=1 at a rising clk edge, set credit_cnt=CREDITS, tx_valid=0, tx_data=0, and err=0.
REQ-026 SHALL, on reset mid-stream, discard any beat accepted in the reset cycle and ignore credit_ret in that cycle; the receiver is reset together with this block.

Configuration
REQ-027 SHALL support the macro CREDIT_TX_BYPASS_EN:
- When defined: with credit_cnt=0 and credit_ret=1 in the same cycle, w_ready=1 and the returned credit is consumed immediately, so credit_cnt stays 0.
- When undefined: w_ready depends on the registered credit_cnt only, and the returned credit is usable from the next cycle.

Verification
REQ-028 SHALL verify reset and drain (CREDITS=4, DATA_WIDTH=8): after reset, send 0x11,0x22,0x33,0x44 back-to-back with no returns -> four tx_valid pulses one cycle after each handshake, credit_cnt 4->0, then w_ready=0.
REQ-029 SHALL verify refill: from credit_cnt=0, pulse credit_ret once -> credit_cnt=1 next cycle, and the next beat 0x55 is accepted and appears on tx_data one cycle later.
REQ-030 SHALL verify simultaneous events: with credit_cnt=2, hold w_valid=1 and credit_ret=1 for 5 cycles -> credit_cnt stays 2 and 5 consecutive tx_valid pulses.
REQ-031 SHALL verify bypass (CREDITS=4, DATA_WIDTH=8): with credit_cnt=0, w_valid=1 and credit_ret=1 in the same cycle -> with the macro, w_ready=1 that cycle and credit_cnt stays 0; without it, w_ready=0 that cycle, credit_cnt=1 next cycle, and the transfer happens the following cycle.
REQ-032 SHALL verify overflow: with credit_cnt=4, pulse credit_ret -> err=1 next cycle, credit_cnt stays 4, and err remains 1 until rst.
REQ-033 SHALL verify mid-stream reset: assert rst during a handshake with credit_cnt=1 -> tx_valid=0 next cycle, credit_cnt=4, err=0.
